// File: rtl/frame_timing_controller.sv
// Double-buffered SLM frame sequencer: paces line loads, issues the buffer-switch update and the DC-balance invert.
// Define FRAME_TIMEOUT_EN to add the line-wait watchdog and the timeout_err output.
module frame_timing_controller #(
   parameter int LINES_PER_FRAME = 1080,
   parameter int SWITCH_CYCLES   = 16,
   parameter int INVERT_PERIOD   = 4096,
   parameter int INVERT_HALVES   = 2,
   parameter int TIMEOUT_CYCLES  = 2**20
) (
   input  logic fpga_clk,
   input  logic reset_all_n,
   input  logic dc32_fifo_almost_full,
   input  logic line_read_done,
   output logic line_of_data_available,
   output logic [((LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1)-1:0] line_addr,
   output logic update,
   output logic buffer_switch_done,
   output logic reset_per_frame,
   output logic invert
`ifdef FRAME_TIMEOUT_EN
   ,
   output logic timeout_err
`endif
);

   localparam int AW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
   localparam int CW = (INVERT_PERIOD > 1) ? $clog2(INVERT_PERIOD) : 1;
   localparam int HW = $clog2(INVERT_HALVES + 1);
   localparam int SW = (SWITCH_CYCLES > 1) ? $clog2(SWITCH_CYCLES) : 1;

   localparam logic [AW-1:0] ADDR_LAST   = AW'(LINES_PER_FRAME - 1);
   localparam logic [CW-1:0] CNT_LAST    = CW'(INVERT_PERIOD - 1);
   localparam logic [HW-1:0] HALVES_LAST = HW'(INVERT_HALVES - 1);
   localparam logic [SW-1:0] SW_LAST     = SW'(SWITCH_CYCLES - 1);

   typedef enum logic [1:0] {L_WAIT, L_BUSY, L_FULL} load_state_t;
   typedef enum logic {D_RUN, D_DONE} disp_state_t;
   typedef enum logic {S_IDLE, S_SWITCH} sw_state_t;

   load_state_t   load_q, load_d;
   disp_state_t   disp_q, disp_d;
   sw_state_t     sw_state_q, sw_state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [HW-1:0] halves_q, halves_d;
   logic [SW-1:0] sw_cnt_q, sw_cnt_d;
   logic          grant_q, grant_d;
   logic          update_q, update_d;
   logic          done_q, done_d;
   logic          rpf_q, rpf_d;
   logic          invert_q, invert_d;
`ifdef FRAME_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
   logic [WW-1:0] wd_q, wd_d;
   logic          timeout_q, timeout_d;
`endif

   always_comb begin
      load_d     = load_q;
      disp_d     = disp_q;
      sw_state_d = sw_state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      halves_d   = halves_q;
      sw_cnt_d   = sw_cnt_q;
      grant_d    = grant_q;
      update_d   = update_q;
      invert_d   = invert_q;
      done_d     = 1'b0;
      rpf_d      = 1'b0;
`ifdef FRAME_TIMEOUT_EN
      wd_d       = '0;
      timeout_d  = timeout_q;
`endif

      case (load_q)
         L_WAIT: begin
            if (dc32_fifo_almost_full) begin
               load_d  = L_BUSY;
               grant_d = 1'b1;
            end
         end
         L_BUSY: begin
            if (line_read_done) begin
               grant_d = 1'b0;
               if (addr_q == ADDR_LAST) begin
                  load_d = L_FULL;
               end else begin
                  addr_d = addr_q + AW'(1);
                  load_d = L_WAIT;
               end
            end
         end
         default: ;
      endcase

`ifdef FRAME_TIMEOUT_EN
      // Give up on a stalled FIFO: the frame is switched with whatever the back buffer holds.
      if (load_q == L_WAIT && !dc32_fifo_almost_full) begin
         if (wd_q == WD_LAST) begin
            timeout_d = 1'b1;
            load_d    = L_FULL;
         end else begin
            wd_d = wd_q + WW'(1);
         end
      end
`endif

      if (disp_q == D_RUN) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            invert_d = ~invert_q;
            if (halves_q == HALVES_LAST) begin
               disp_d   = D_DONE;
               invert_d = 1'b0;
            end else begin
               halves_d = halves_q + HW'(1);
            end
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      // Completing a switch restarts both the loader and the display for the next frame.
      case (sw_state_q)
         S_IDLE: begin
            if (load_q == L_FULL && disp_q == D_DONE) begin
               sw_state_d = S_SWITCH;
               update_d   = 1'b1;
               sw_cnt_d   = '0;
            end
         end
         default: begin
            if (sw_cnt_q == SW_LAST) begin
               sw_state_d = S_IDLE;
               update_d   = 1'b0;
               done_d     = 1'b1;
               rpf_d      = 1'b1;
               addr_d     = '0;
               load_d     = L_WAIT;
               grant_d    = 1'b0;
               disp_d     = D_RUN;
               cnt_d      = '0;
               halves_d   = '0;
               invert_d   = 1'b0;
            end else begin
               sw_cnt_d = sw_cnt_q + SW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge fpga_clk) begin
      if (!reset_all_n) begin
         load_q     <= L_WAIT;
         disp_q     <= D_DONE;
         sw_state_q <= S_IDLE;
         addr_q     <= '0;
         cnt_q      <= '0;
         halves_q   <= '0;
         sw_cnt_q   <= '0;
         grant_q    <= 1'b0;
         update_q   <= 1'b0;
         done_q     <= 1'b0;
         rpf_q      <= 1'b0;
         invert_q   <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
         wd_q       <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         load_q     <= load_d;
         disp_q     <= disp_d;
         sw_state_q <= sw_state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         halves_q   <= halves_d;
         sw_cnt_q   <= sw_cnt_d;
         grant_q    <= grant_d;
         update_q   <= update_d;
         done_q     <= done_d;
         rpf_q      <= rpf_d;
         invert_q   <= invert_d;
`ifdef FRAME_TIMEOUT_EN
         wd_q       <= wd_d;
         timeout_q  <= timeout_d;
`endif
      end
   end

   assign line_of_data_available = grant_q;
   assign line_addr              = addr_q;
   assign update                 = update_q;
   assign buffer_switch_done     = done_q;
   assign reset_per_frame        = rpf_q;
   assign invert                 = invert_q;
`ifdef FRAME_TIMEOUT_EN
   assign timeout_err            = timeout_q;
`endif

endmodule

// File: tb/tb_frame_timing_controller.sv
// Directed bench for frame_timing_controller (4 lines, 3-cycle update, 8-cycle invert halves, 50-cycle watchdog).
module tb_frame_timing_controller;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       af;
   logic       lrd;
   logic       grant;
   logic [1:0] line_addr;
   logic       update;
   logic       done;
   logic       rpf;
   logic       invert;
`ifdef FRAME_TIMEOUT_EN
   logic       timeout_err;
   localparam int IDLE_CYCLES = 40;
`else
   localparam int IDLE_CYCLES = 100;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   frame_timing_controller #(
      .LINES_PER_FRAME(4),
      .SWITCH_CYCLES  (3),
      .INVERT_PERIOD  (8),
      .INVERT_HALVES  (2),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .fpga_clk              (clk),
      .reset_all_n           (reset_n),
      .dc32_fifo_almost_full (af),
      .line_read_done        (lrd),
      .line_of_data_available(grant),
      .line_addr             (line_addr),
      .update                (update),
      .buffer_switch_done    (done),
      .reset_per_frame       (rpf),
      .invert                (invert)
`ifdef FRAME_TIMEOUT_EN
      ,
      .timeout_err           (timeout_err)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic serve_line(input int exp_addr, input int delay);
      int waited = 0;
      while (grant !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      chk("grant_seen", 32'(grant), 1);
      chk("line_addr", 32'(line_addr), 32'(exp_addr));
      repeat (delay) begin
         @(negedge clk);
         chk("grant_hold", 32'(grant), 1);
      end
      lrd = 1'b1;
      @(negedge clk);
      lrd = 1'b0;
      chk("grant_drop", 32'(grant), 0);
      $display("line %0d served", exp_addr);
   endtask

   initial begin
      int lines;
      int exp_inv;
      bit found;
      reset_n = 1'b0;
      af      = 1'b0;
      lrd     = 1'b0;

      // 1. reset and idle
      repeat (5) @(negedge clk);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_addr", 32'(line_addr), 0);
      chk("rst_update", 32'(update), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_rpf", 32'(rpf), 0);
      chk("rst_invert", 32'(invert), 0);
`ifdef FRAME_TIMEOUT_EN
      chk("rst_timeout", 32'(timeout_err), 0);
`endif
      reset_n = 1'b1;
      for (int i = 0; i < IDLE_CYCLES; i++) begin
         @(negedge clk);
         chk("idle_grant", 32'(grant), 0);
         chk("idle_update", 32'(update), 0);
      end
      chk("idle_addr", 32'(line_addr), 0);
      $display("idle phase: %0d cycles without grant", IDLE_CYCLES);

      // 2. first frame: switch follows last line immediately
      af = 1'b1;
      for (int l = 0; l < 4; l++) serve_line(l, 3);
      chk("f1_addr_hold", 32'(line_addr), 3);
      chk("f1_update_lo", 32'(update), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("f1_update_hi", 32'(update), 1);
         chk("f1_done_lo", 32'(done), 0);
      end
      @(negedge clk);
      chk("f1_update_fall", 32'(update), 0);
      chk("f1_done", 32'(done), 1);
      chk("f1_rpf", 32'(rpf), 1);
      chk("f1_addr_clr", 32'(line_addr), 0);
      $display("frame 1 switched");

      // 3. second frame, FIFO always full: display paces the switch
      lines = 0;
      for (int k = 0; k <= 20; k++) begin
         if (k > 0) @(negedge clk);
         exp_inv = (k >= 8 && k < 16) ? 1 : 0;
         chk("f2_invert", 32'(invert), 32'(exp_inv));
         chk("f2_update", 32'(update), (k >= 17 && k <= 19) ? 1 : 0);
         chk("f2_done", 32'(done), (k == 0 || k == 20) ? 1 : 0);
         if (grant === 1'b1) begin
            chk("f2_addr", 32'(line_addr), 32'(lines));
            lines++;
         end
         lrd = grant;
      end
      lrd = 1'b0;
      chk("f2_lines", 32'(lines), 4);
      $display("frame 2 switched after %0d lines", lines);

      // 4. third frame: loading lags the display
      af = 1'b0;
      for (int j = 1; j <= 24; j++) begin
         @(negedge clk);
         exp_inv = (j >= 8 && j < 16) ? 1 : 0;
         chk("f3_invert", 32'(invert), 32'(exp_inv));
         chk("f3_update", 32'(update), 0);
         chk("f3_grant", 32'(grant), 0);
      end
      af = 1'b1;
      for (int l = 0; l < 4; l++) serve_line(l, 3);
      chk("f3_invert_wait", 32'(invert), 0);
      chk("f3_update_lo", 32'(update), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("f3_update_hi", 32'(update), 1);
         chk("f3_invert_sw", 32'(invert), 0);
      end
      @(negedge clk);
      chk("f3_update_fall", 32'(update), 0);
      chk("f3_done", 32'(done), 1);
      $display("frame 3 switched");

      // 5. reset on the second update cycle
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         lrd = grant;
         if (update === 1'b1) found = 1'b1;
      end
      lrd = 1'b0;
      chk("f4_update_seen", 32'(found), 1);
      @(negedge clk);
      chk("f4_update_2nd", 32'(update), 1);
      chk("f4_addr_full", 32'(line_addr), 3);
      reset_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_update", 32'(update), 0);
      chk("mid_rst_invert", 32'(invert), 0);
      chk("mid_rst_addr", 32'(line_addr), 0);
      chk("mid_rst_done", 32'(done), 0);
      chk("mid_rst_grant", 32'(grant), 0);
      repeat (2) begin
         @(negedge clk);
         chk("mid_rst_done_hold", 32'(done), 0);
      end
      af = 1'b0;
      reset_n = 1'b1;
      $display("reset during switch applied");

`ifdef FRAME_TIMEOUT_EN
      // 6. watchdog expiry with the FIFO never filling
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         chk("wd_timeout", 32'(timeout_err), (i >= 50) ? 1 : 0);
         chk("wd_update", 32'(update), (i >= 51 && i <= 53) ? 1 : 0);
         chk("wd_done", 32'(done), (i == 54) ? 1 : 0);
         chk("wd_grant", 32'(grant), 0);
      end
      $display("watchdog frame switched, timeout_err=%0b", timeout_err);
`else
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         chk("post_grant", 32'(grant), 0);
         chk("post_update", 32'(update), 0);
      end
      $display("post-reset idle held");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
